// File: rtl/golden_nonce_tx_pkg.sv
// Shared encodings and defaults for the golden-nonce return path.
package golden_nonce_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_st_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_SEND = 1'b1
  } seq_e;

  localparam int DEF_BAUD_DIV   = 434;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_tx_byte.sv
// One UART 8N1 byte framer; start in the last stop cycle chains the next byte with no gap.
module uart_tx_byte
  import golden_nonce_tx_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       hash_clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       start,
  output logic       done,
  output logic       txd
);

  uart_st_e    state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic        tc;

  assign tc  = (baud_q == 16'(BAUD_DIV - 1));
  assign txd = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (start) begin
          sh_d    = byte_in;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tc) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tc) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tc) begin
          baud_d = '0;
          done   = 1'b1;
          if (start) begin
            sh_d    = byte_in;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Line level follows the current state, so txd trails the state by one cycle.
    txd_d = 1'b1;
    if (state_q == ST_START)     txd_d = 1'b0;
    else if (state_q == ST_DATA) txd_d = sh_q[0];
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/golden_nonce_tx.sv
// Golden-nonce FIFO, little-endian byte sequencer and saturating drop counter feeding a UART.
module golden_nonce_tx
  import golden_nonce_tx_pkg::*;
#(
  parameter int BAUD_DIV   = DEF_BAUD_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        hash_clk,
  input  logic        reset,
  input  logic [31:0] nonce_in,
  input  logic        nonce_valid,
  output logic        nonce_ready,
  output logic        txd,
  output logic        busy,
  output logic [7:0]  drop_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   head;
  logic          full, empty, push, pop;

  seq_e          seq_q, seq_d;
  logic [23:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    drop_q;
  logic          tx_start, tx_done;
  logic [7:0]    tx_byte;

  assign head        = mem_q[rd_q];
  assign full        = (cnt_q == CW'(FIFO_DEPTH));
  assign empty       = (cnt_q == '0);
  assign push        = nonce_valid && !full;
  assign nonce_ready = !full;
  assign busy        = (seq_q != SEQ_IDLE) || !empty;
  assign drop_count  = drop_q;

  always_comb begin
    seq_d    = seq_q;
    word_d   = word_q;
    idx_d    = idx_q;
    tx_start = 1'b0;
    tx_byte  = word_q[7:0];
    pop      = 1'b0;
    if (seq_q == SEQ_IDLE && !empty) begin
      pop      = 1'b1;
      tx_start = 1'b1;
      tx_byte  = head[7:0];
      word_d   = head[31:8];
      idx_d    = 2'd0;
      seq_d    = SEQ_SEND;
    end else if (seq_q == SEQ_SEND && tx_done) begin
      if (idx_q == 2'd3) begin
        seq_d = SEQ_IDLE;
      end else begin
        tx_start = 1'b1;
        word_d   = {8'h00, word_q[23:8]};
        idx_d    = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge hash_clk) begin
    if (push) mem_q[wr_q] <= nonce_in;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      seq_q  <= SEQ_IDLE;
      word_q <= '0;
      idx_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      if (nonce_valid && full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      seq_q  <= seq_d;
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .hash_clk(hash_clk),
    .reset   (reset),
    .byte_in (tx_byte),
    .start   (tx_start),
    .done    (tx_done),
    .txd     (txd)
  );

endmodule
